// File: rtl/c_result_reader.sv
// Drains the NxN result matrix from the N column-banked BRAM C banks as a row-major
// valid/ready word stream, double-buffering whole rows so the stream has no gaps.
module c_result_reader #(
  parameter int unsigned N  = 16,
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 8,
  localparam int unsigned RW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  output logic            o_busy,
  output logic            o_done,
  output logic [N*AW-1:0] o_bram_c_addr,
  input  logic [N*DW-1:0] i_bram_c_rdata,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [DW-1:0]   o_out_data,
  output logic [RW-1:0]   o_out_row,
  output logic [RW-1:0]   o_out_col,
  output logic            o_out_last
);

  localparam int unsigned FW = $clog2(N + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          r_state;
  state_e          w_state_next;
  logic [FW-1:0]   r_fetch_row;
  logic            r_pending;
  logic            r_wr_slot;
  logic            r_rd_slot;
  logic [1:0]      r_full;
  logic [DW-1:0]   r_buf [2][N];
  logic [RW-1:0]   r_out_row;
  logic [RW-1:0]   r_out_col;

  logic w_run;
  logic w_issue;
  logic w_valid;
  logic w_hs;
  logic w_col_last;
  logic w_last_word;

  assign w_run       = (r_state == StRun);
  // Eligibility uses only registered flags, so a slot freed this cycle is reused next cycle.
  assign w_issue     = w_run && (r_fetch_row < FW'(N)) && !r_pending && !r_full[r_wr_slot];
  assign w_valid     = w_run && r_full[r_rd_slot];
  assign w_hs        = w_valid && i_out_ready;
  assign w_col_last  = (r_out_col == RW'(N - 1));
  assign w_last_word = w_col_last && (r_out_row == RW'(N - 1));

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (i_start) w_state_next = StRun;
      StRun:   if (w_hs && w_last_word) w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_fetch_row <= '0;
      r_pending   <= 1'b0;
      r_wr_slot   <= 1'b0;
      r_rd_slot   <= 1'b0;
      r_full      <= 2'b00;
      r_out_row   <= '0;
      r_out_col   <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == StIdle && i_start) begin
        r_fetch_row <= '0;
        r_pending   <= 1'b0;
        r_wr_slot   <= 1'b0;
        r_rd_slot   <= 1'b0;
        r_full      <= 2'b00;
        r_out_row   <= '0;
        r_out_col   <= '0;
      end else if (w_run) begin
        if (w_issue) begin
          r_pending   <= 1'b1;
          r_fetch_row <= r_fetch_row + FW'(1);
        end
        if (r_pending) begin
          r_pending         <= 1'b0;
          r_full[r_wr_slot] <= 1'b1;
          r_wr_slot         <= ~r_wr_slot;
        end
        if (w_hs) begin
          if (w_col_last) begin
            r_out_col         <= '0;
            r_out_row         <= r_out_row + RW'(1);
            r_full[r_rd_slot] <= 1'b0;
            r_rd_slot         <= ~r_rd_slot;
          end else begin
            r_out_col <= r_out_col + RW'(1);
          end
        end
      end
    end
  end

  // Row storage carries data only; validity lives in r_full, so no reset is needed here.
  always_ff @(posedge i_clk) begin
    if (w_run && r_pending) begin
      for (int i = 0; i < int'(N); i++) begin
        r_buf[r_wr_slot][i] <= i_bram_c_rdata[i*DW +: DW];
      end
    end
  end

  always_comb begin
    o_bram_c_addr = '0;
    if (w_issue) begin
      for (int i = 0; i < int'(N); i++) begin
        o_bram_c_addr[i*AW +: AW] = AW'(r_fetch_row);
      end
    end
  end

  assign o_busy      = (r_state != StIdle);
  assign o_done      = (r_state == StDone);
  assign o_out_valid = w_valid;
  assign o_out_data  = w_valid ? r_buf[r_rd_slot][r_out_col] : '0;
  assign o_out_row   = w_valid ? r_out_row : '0;
  assign o_out_col   = w_valid ? r_out_col : '0;
  assign o_out_last  = w_valid && w_last_word;

endmodule

// File: tb/tb_c_result_reader.sv
// Bench for c_result_reader: an N=16 instance exercised under several ready patterns,
// start/reset corner cases, and an N=4 instance checked against a vector table.
module tb_c_result_reader;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         busy;
  logic         done;
  logic [127:0] addr;
  logic [511:0] rdata;
  logic         valid;
  logic         ready;
  logic [31:0]  data;
  logic [3:0]   row;
  logic [3:0]   col;
  logic         last;

  logic         start4;
  logic         busy4;
  logic         done4;
  logic [31:0]  addr4;
  logic [127:0] rdata4;
  logic         valid4;
  logic         ready4;
  logic [31:0]  data4;
  logic [1:0]   row4;
  logic [1:0]   col4;
  logic         last4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  c_result_reader #(.N(16), .DW(32), .AW(8)) dut16 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .o_busy(busy), .o_done(done),
    .o_bram_c_addr(addr), .i_bram_c_rdata(rdata), .o_out_valid(valid),
    .i_out_ready(ready), .o_out_data(data), .o_out_row(row), .o_out_col(col),
    .o_out_last(last)
  );

  c_result_reader #(.N(4), .DW(32), .AW(8)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_start(start4), .o_busy(busy4), .o_done(done4),
    .o_bram_c_addr(addr4), .i_bram_c_rdata(rdata4), .o_out_valid(valid4),
    .i_out_ready(ready4), .o_out_data(data4), .o_out_row(row4), .o_out_col(col4),
    .o_out_last(last4)
  );

  // BRAM models: one-cycle read latency, bank c holds column c.
  always_ff @(posedge clk) begin
    for (int c = 0; c < 16; c++) begin
      rdata[c*32 +: 32] <= 32'(addr[c*8 +: 8]) * 32'd256 + 32'(c);
    end
    for (int c = 0; c < 4; c++) begin
      rdata4[c*32 +: 32] <= 32'(addr4[c*8 +: 8]) * 32'd16 + 32'(c);
    end
  end

  typedef struct {
    logic [31:0] data;
    logic [1:0]  row;
    logic [1:0]  col;
    logic        last;
  } vec_t;

  vec_t vec4 [16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // mode 0: ready=1; 1: random ready; 2: 40-cycle stall on word 5; 3: reset during row 7.
  task automatic run16(input int mode);
    int cyc = 1, idx = 0, first_cyc = -1, hs_cyc = -1, done_cyc = -1;
    int issues = 0, bank_mis = 0, hold = 0, hold_issues = 0, issues_at_hold = -1;
    bit fin = 0, rst_pend = 0, pv = 0, pr = 0;
    logic [40:0] held = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!fin && cyc < 3000) begin
      if (rst_pend) begin
        check("rst outputs", 64'({busy, done, valid, last, data, row, col}), 64'd0);
        check("rst addr", 64'(|addr), 64'd0);
        rst = 1'b0;
        fin = 1;
        break;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        check("idle after done", 64'({busy, done}), 64'd0);
        start = 1'b0;
        fin = 1;
        break;
      end
      for (int c = 1; c < 16; c++) if (addr[c*8 +: 8] != addr[7:0]) bank_mis++;
      if (addr[7:0] != 8'd0) begin
        issues++;
        if (pv && !pr) hold_issues++;
      end
      if (pv && !pr) check("hold stable", 64'({data, row, col, last}), 64'(held));
      start = (cyc == 100);
      case (mode)
        1:       ready = 1'($urandom_range(0, 1));
        2: begin
          ready = !(valid && idx == 5 && hold < 40);
          if (!ready) begin
            hold++;
            if (hold == 40) issues_at_hold = issues;
          end
        end
        default: ready = 1'b1;
      endcase
      if (valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (ready) begin
          check($sformatf("word %0d", idx), 64'({data, row, col, last}),
                64'({32'((idx / 16) * 256 + idx % 16), 4'(idx / 16), 4'(idx % 16), idx == 255}));
          idx++;
          if (idx == 256) hs_cyc = cyc;
        end
      end
      if (mode == 3 && valid && row == 4'd7 && col == 4'd1) begin
        rst = 1'b1;
        rst_pend = 1;
      end
      if (done) begin
        done_cyc = cyc;
        start = 1'b1;
      end
      pv = valid;
      pr = ready;
      held = {data, row, col, last};
      @(negedge clk);
      cyc++;
    end
    if (!fin) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout mode %0d: no completion within %0d cycles", mode, cyc);
      rst = 1'b0;
      start = 1'b0;
    end else if (mode != 3) begin
      check("first valid cycle", 64'(first_cyc), 64'd3);
      check("word count", 64'(idx), 64'd256);
      check("done after last hs", 64'(done_cyc), 64'(hs_cyc + 1));
      check("issue count", 64'(issues), 64'd15);
      check("banks agree", 64'(bank_mis), 64'd0);
      if (mode == 0) check("done cycle", 64'(done_cyc), 64'd259);
      if (mode == 2) begin
        check("stall length", 64'(hold), 64'd40);
        check("no issue in stall", 64'(hold_issues), 64'd0);
        check("rows buffered at stall", 64'(issues_at_hold), 64'd1);
      end
    end
  endtask

  task automatic run4();
    int cyc = 1, idx = 0, first_cyc = -1, done_cyc = -1;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    while (done_cyc < 0 && cyc < 200) begin
      if (valid4) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (idx < 16) begin
          check($sformatf("n4 word %0d", idx), 64'({data4, row4, col4, last4}),
                64'({vec4[idx].data, vec4[idx].row, vec4[idx].col, vec4[idx].last}));
        end
        idx++;
      end
      if (done4) done_cyc = cyc;
      @(negedge clk);
      cyc++;
    end
    check("n4 first valid", 64'(first_cyc), 64'd3);
    check("n4 word count", 64'(idx), 64'd16);
    check("n4 done cycle", 64'(done_cyc), 64'd19);
    check("n4 idle", 64'(busy4), 64'd0);
  endtask

  initial begin
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        vec4[r*4 + c] = '{data: 32'(16 * r + c), row: 2'(r), col: 2'(c),
                          last: (r == 3 && c == 3)};
      end
    end
    rst = 1'b1;
    start = 1'b0;
    start4 = 1'b0;
    ready = 1'b0;
    ready4 = 1'b1;
    repeat (3) @(negedge clk);
    check("reset busy/done", 64'({busy, done}), 64'd0);
    check("reset valid/last", 64'({valid, last}), 64'd0);
    check("reset data/row/col", 64'({data, row, col}), 64'd0);
    check("reset addr", 64'(|addr), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle holds busy low", 64'(busy), 64'd0);
    run16(0);
    run16(1);
    run16(2);
    run16(3);
    run16(0);
    run4();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/c_result_reader.md
# c_result_reader

Drains the N×N 32-bit result matrix from the N BRAM C banks after the compute unit has stored it. Streams it to a single-word valid/ready output port, row-major: row 0 col 0 first, row N-1 col N-1 last. Sits on the read side of BRAM C, between the result memory and the host/output path. Ping-pong row buffers keep output throughput at one word per cycle under continuous ready.

## Interface
- N, 16, matrix dimension; also the number of BRAM C banks (bank c holds column c)
- DW, 32, result word width
- AW, 8, BRAM address width; the row index sits in the low bits, upper bits are zero
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- start  in  1  begin a readout; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last word is accepted
- bram_c_addr  out  N×AW  per-bank read address; all banks are driven with the same row
- bram_c_rdata  in  N×DW  per-bank read data; valid the cycle after the address
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts the word when out_valid && out_ready
- out_data  out  DW  result word C[out_row][out_col]
- out_row  out  clog2(N)  row index of out_data
- out_col  out  clog2(N)  column index of out_data
- out_last  out  1  high only with word (N-1, N-1)

## Operation
- States: IDLE, RUN, DONE.
  - IDLE → RUN when start=1. This clears fetch_row, out row/col, both slot-full flags and the read slot pointer.
  - RUN → DONE on the handshake of the word with out_last=1.
  - DONE → IDLE unconditionally. done=1 only in DONE.
- Fetch engine (RUN only):
  - Issues a read of row fetch_row in a cycle when all three hold: fetch_row < N, no read is pending, and slot wr_slot is empty.
  - Issue means bram_c_addr[i] = fetch_row for all i. Set pending, then fetch_row++.
  - The cycle after an issue, all N rdata words are captured into slot wr_slot. That slot is marked full, pending clears and wr_slot toggles.
  - When no read is issued, bram_c_addr = 0.
- Stream engine:
  - out_valid = RUN && slot rd_slot full.
  - out_data = slot[rd_slot][out_col]. out_row and out_col come from the drain counters.
  - On each handshake, out_col++.
  - On the handshake at out_col = N-1: out_col → 0, out_row++, slot rd_slot marked empty, rd_slot toggles.
- A slot freed by a handshake in cycle t is eligible for a new issue in cycle t+1. Issue eligibility is evaluated on registered flags.
- Since N ≥ 2 and a row fetch takes 2 cycles, the next row is always buffered before the current row drains. There are no bubbles once streaming starts.
- start is ignored in RUN and DONE, including start asserted in the DONE cycle.
- Stability: while out_valid=1 and out_ready=0, out_data, out_row, out_col and out_last hold.
- No arithmetic on the data. Words pass through unmodified at DW bits.
- When out_valid=0, out_data, out_row, out_col and out_last are 0.

## Timing
- Reset values: busy, done, out_valid, out_last = 0; out_data, out_row, out_col = 0; bram_c_addr = 0. State is IDLE, both slots are empty, pending = 0.
- Reset in any state (including mid-row, or with a read pending) returns to these values on the next edge. Returned rdata is discarded. No partial stream resumes.
- Startup latency (start sampled at edge 0):
  - cycle 1: RUN, row 0 address driven.
  - cycle 2: capture.
  - cycle 3: out_valid=1 with C[0][0]. In the same cycle, row 1 is issued.
- With out_ready held at 1:
  - N² consecutive handshakes, cycles 3 .. N²+2.
  - done=1 at cycle N²+3.
  - IDLE at cycle N²+4. start is honored from cycle N²+4.
- Backpressure:
  - At most two rows are buffered, plus zero pending reads once both slots are full.
  - No address is issued while both slots are full.
- Each BRAM row is read exactly once per readout. Exactly N issues occur between start and done.

## Test plan
- N=16, BRAM model C[r][c] = r·256 + c, out_ready=1, start at cycle 0 → out_valid first at cycle 3 with out_data=0x0000. Then 256 gapless words in row-major order. out_last only on word 0x0F0F. done pulse at cycle 259, busy low at 260.
- Same data, out_ready random at 50% → identical word sequence. Every valid&&!ready cycle holds data/row/col stable. done occurs one cycle after the 256th handshake.
- out_ready=0 for 40 cycles while row 0 col 5 is presented → out_data stays 0x0005. Exactly rows 0 and 1 are addressed, with no further non-zero addresses. On release, the stream resumes at 0x0005 with no loss or duplication.
- start pulsed mid-RUN and in the DONE cycle → ignored, with no restart or extra issue. start in the following IDLE cycle → new readout with first word 0x0000 three cycles later.
- rst asserted while streaming row 7 with a read pending → next cycle all outputs are 0 and busy=0. A subsequent start restarts from C[0][0].
- N=4 build, C[r][c] = 16r + c, ready=1 → 16 words 0x00..0x33 (C[r][c] = 16r + c) in order. out_last on 0x33. done at cycle 19.
